// File: rtl/req_join_sched_pkg.sv
// Shared definitions for the request fork/join scheduler: FSM encoding and
// default sizing constants.
package req_join_sched_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_WAIT = 1'b1
  } state_e;

  localparam int REQ_NUM_DEF        = 4;
  localparam int TIMEOUT_CYCLES_DEF = 1024;

endpackage : req_join_sched_pkg

// File: rtl/req_join_sched_done_collector.sv
// Sticky per-channel completion bits for one round. Bits set only on
// enabled channels, clear synchronously when a new round is launched, and
// all_done looks through to the current cycle's done pulses so completion
// is seen without an extra cycle of latency.
module req_join_sched_done_collector #(
  parameter int REQ_NUM = 4
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               clr,
  input  logic               en,
  input  logic [REQ_NUM-1:0] active,
  input  logic [REQ_NUM-1:0] done,
  output logic [REQ_NUM-1:0] collected_nxt,
  output logic               all_done
);

  logic [REQ_NUM-1:0] collected_d;
  logic [REQ_NUM-1:0] collected_q;

  // Next sticky vector: clear wins, otherwise OR in done on active channels.
  always_comb begin
    // NOTE: every signal written here gets a default first so no path leaves
    // it unassigned; a missing default would infer a latch.
    collected_d = collected_q;
    if (clr) begin
      collected_d = '0;
    end else if (en) begin
      collected_d = collected_q | (done & active);
    end
  end

  // Register the sticky vector.
  always_ff @(posedge clk or negedge rstn) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rstn) begin
      collected_q <= '0;
    end else begin
      collected_q <= collected_d;
    end
  end

  assign collected_nxt = collected_d;
  assign all_done      = ((collected_q | (done & active)) == active);

endmodule : req_join_sched_done_collector

// File: rtl/req_join_sched.sv
// Synchronous fork/join scheduler. A start launches one-cycle go pulses to
// the masked workers, their done pulses are collected, and the round ends
// with fin (all reported), timeout (counter expired) or a silent abort.
module req_join_sched
  import req_join_sched_pkg::*;
#(
  parameter int REQ_NUM        = REQ_NUM_DEF,
  parameter int TIMEOUT_CYCLES = TIMEOUT_CYCLES_DEF,
  parameter int CNT_W          = $clog2(TIMEOUT_CYCLES)
) (
  input  logic               clk,
  input  logic               rstn,
  input  logic               start,
  input  logic [REQ_NUM-1:0] mask,
  input  logic               abort,
  output logic [REQ_NUM-1:0] go,
  input  logic [REQ_NUM-1:0] done,
  output logic               fin,
  output logic               timeout,
  output logic               busy,
  output logic [REQ_NUM-1:0] pending
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

  state_e             state_d,   state_q;
  logic [REQ_NUM-1:0] active_d,  active_q;
  logic [CNT_W-1:0]   cnt_d,     cnt_q;
  logic [REQ_NUM-1:0] go_d,      go_q;
  logic               fin_d,     fin_q;
  logic               timeout_d, timeout_q;
  logic               busy_d,    busy_q;
  logic [REQ_NUM-1:0] pending_d, pending_q;

  logic               col_clr;
  logic               col_en;
  logic [REQ_NUM-1:0] collected_nxt;
  logic               all_done;

  req_join_sched_done_collector #(
    .REQ_NUM (REQ_NUM)
  ) u_collector (
    .clk           (clk),
    .rstn          (rstn),
    .clr           (col_clr),
    .en            (col_en),
    .active        (active_q),
    .done          (done),
    .collected_nxt (collected_nxt),
    .all_done      (all_done)
  );

  // Next-state, counter and registered-output logic for the join FSM.
  always_comb begin
    state_d   = state_q;
    active_d  = active_q;
    cnt_d     = cnt_q;
    go_d      = '0;
    fin_d     = 1'b0;
    timeout_d = 1'b0;
    busy_d    = busy_q;
    pending_d = pending_q;
    col_clr   = 1'b0;
    col_en    = 1'b0;

    unique case (state_q)
      ST_IDLE: begin
        if (start) begin
          if (mask != '0) begin
            state_d   = ST_WAIT;
            active_d  = mask;
            cnt_d     = '0;
            go_d      = mask;
            busy_d    = 1'b1;
            pending_d = mask;
            col_clr   = 1'b1;
          end else begin
            // Empty round completes immediately without leaving IDLE.
            fin_d     = 1'b1;
            pending_d = '0;
          end
        end
      end

      ST_WAIT: begin
        col_en    = 1'b1;
        cnt_d     = cnt_q + CNT_W'(1);
        pending_d = active_q & ~collected_nxt;
        // Priority: abort, then completion, then timeout.
        if (abort) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          pending_d = '0;
        end else if (all_done) begin
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          fin_d     = 1'b1;
        end else if (cnt_q == CNT_LAST) begin
          // pending keeps the unreported channels for diagnosis.
          state_d   = ST_IDLE;
          busy_d    = 1'b0;
          timeout_d = 1'b1;
        end
      end

      default: state_d = ST_IDLE;
    endcase
  end

  // Single register bank for FSM state, round context and all outputs.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      state_q   <= ST_IDLE;
      active_q  <= '0;
      cnt_q     <= '0;
      go_q      <= '0;
      fin_q     <= 1'b0;
      timeout_q <= 1'b0;
      busy_q    <= 1'b0;
      pending_q <= '0;
    end else begin
      state_q   <= state_d;
      active_q  <= active_d;
      cnt_q     <= cnt_d;
      go_q      <= go_d;
      fin_q     <= fin_d;
      timeout_q <= timeout_d;
      busy_q    <= busy_d;
      pending_q <= pending_d;
    end
  end

  assign go      = go_q;
  assign fin     = fin_q;
  assign timeout = timeout_q;
  assign busy    = busy_q;
  assign pending = pending_q;

endmodule : req_join_sched

// File: tb/tb_req_join_sched.sv
// Directed bench for req_join_sched with REQ_NUM=4 and a short timeout.
// Inputs change 1 ns after the rising edge; outputs are observed at the same
// point, so "cycle r" means the interval after the r-th edge since start.
module tb_req_join_sched;

  localparam int N  = 4;
  localparam int TC = 16;

  logic         clk   = 1'b0;
  logic         rstn  = 1'b0;
  logic         start = 1'b0;
  logic         abort = 1'b0;
  logic [N-1:0] mask  = '0;
  logic [N-1:0] done  = '0;
  logic [N-1:0] go;
  logic [N-1:0] pending;
  logic         fin;
  logic         timeout;
  logic         busy;

  int total = 0;
  int bad   = 0;

  // Expected output vector: {go, fin, timeout, busy, pending}.
  logic [10:0]  exp_v;
  logic [N-1:0] go_e;
  logic [N-1:0] pend_e;
  logic         fin_e;
  logic         to_e;
  logic         busy_e;

  always #5 clk = ~clk;

  req_join_sched #(
    .REQ_NUM        (N),
    .TIMEOUT_CYCLES (TC)
  ) dut (
    .clk     (clk),
    .rstn    (rstn),
    .start   (start),
    .mask    (mask),
    .abort   (abort),
    .go      (go),
    .done    (done),
    .fin     (fin),
    .timeout (timeout),
    .busy    (busy),
    .pending (pending)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [10:0] obs();
    return {go, fin, timeout, busy, pending};
  endfunction

  task automatic launch(input logic [N-1:0] m);
    start = 1'b1;
    mask  = m;
    step();
    start = 1'b0;
    mask  = '0;
  endtask

  task automatic test_reset();
    start = 1'b1;
    mask  = 4'b1111;
    done  = 4'b1111;
    repeat (3) step();
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL reset_hold: got %b want %b", obs(), 11'b0);
    end
    start = 1'b0;
    mask  = '0;
    done  = '0;
    rstn  = 1'b1;
    step();
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL reset_release: got %b want %b", obs(), 11'b0);
    end
  endtask

  // All four channels, done at r=3, r=5 (two), r=9 -> fin at r=10.
  task automatic test_full_join();
    launch(4'b1111);
    for (int r = 1; r <= 11; r++) begin
      go_e   = (r == 1) ? 4'b1111 : 4'b0000;
      fin_e  = (r == 10);
      to_e   = 1'b0;
      busy_e = (r < 10);
      pend_e = (r <= 3) ? 4'b1111 : (r <= 5) ? 4'b1110 : (r <= 9) ? 4'b1000 : 4'b0000;
      exp_v  = {go_e, fin_e, to_e, busy_e, pend_e};
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL full_join r=%0d: got %b want %b", r, obs(), exp_v);
      end
      done = (r == 3) ? 4'b0001 : (r == 5) ? 4'b0110 : (r == 9) ? 4'b1000 : 4'b0000;
      step();
    end
    done = '0;
  endtask

  // Only inactive channels report; timeout TC cycles after go, pending held.
  task automatic test_timeout();
    launch(4'b0101);
    for (int r = 1; r <= TC + 3; r++) begin
      go_e   = (r == 1) ? 4'b0101 : 4'b0000;
      fin_e  = 1'b0;
      to_e   = (r == TC + 1);
      busy_e = (r <= TC);
      pend_e = 4'b0101;
      exp_v  = {go_e, fin_e, to_e, busy_e, pend_e};
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL timeout r=%0d: got %b want %b", r, obs(), exp_v);
      end
      done = 4'b1010;
      step();
    end
    done = '0;
  endtask

  // Empty mask finishes at once; a start in that fin cycle is accepted, and
  // a done in the go cycle completes the round.
  task automatic test_degenerate_b2b();
    launch(4'b0000);
    exp_v = {4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    total++;
    if ((obs() & 11'b111_1111_0000) !== exp_v) begin
      bad++;
      $display("FAIL empty_round: got %b want %b", obs() & 11'b111_1111_0000, exp_v);
    end
    launch(4'b0010);
    exp_v = {4'b0010, 1'b0, 1'b0, 1'b1, 4'b0010};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL b2b_go: got %b want %b", obs(), exp_v);
    end
    done = 4'b0010;
    step();
    done = '0;
    exp_v = {4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL done_in_go_cycle: got %b want %b", obs(), exp_v);
    end
    step();
  endtask

  // Final done coincides with the last counter value: completion wins.
  task automatic test_last_done_at_timeout();
    launch(4'b0011);
    for (int r = 1; r <= TC + 1; r++) begin
      go_e   = (r == 1) ? 4'b0011 : 4'b0000;
      fin_e  = (r == TC + 1);
      to_e   = 1'b0;
      busy_e = (r <= TC);
      pend_e = (r <= 2) ? 4'b0011 : (r <= TC) ? 4'b0010 : 4'b0000;
      exp_v  = {go_e, fin_e, to_e, busy_e, pend_e};
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL last_done r=%0d: got %b want %b", r, obs(), exp_v);
      end
      done = (r == 2) ? 4'b0001 : (r == TC) ? 4'b0010 : 4'b0000;
      step();
    end
    done = '0;
  endtask

  // Abort with two channels outstanding; later dones ignored; restart works.
  task automatic test_abort();
    launch(4'b1111);
    for (int r = 1; r <= 9; r++) begin
      go_e   = (r == 1) ? 4'b1111 : 4'b0000;
      fin_e  = 1'b0;
      to_e   = 1'b0;
      busy_e = (r <= 4);
      pend_e = (r <= 2) ? 4'b1111 : (r == 3) ? 4'b1110 : (r == 4) ? 4'b1100 : 4'b0000;
      exp_v  = {go_e, fin_e, to_e, busy_e, pend_e};
      total++;
      if (obs() !== exp_v) begin
        bad++;
        $display("FAIL abort r=%0d: got %b want %b", r, obs(), exp_v);
      end
      abort = (r == 4);
      done  = (r == 2) ? 4'b0001 : (r == 3) ? 4'b0010 :
              (r >= 5 && r <= 8) ? 4'b1111 : 4'b0000;
      step();
    end
    abort = 1'b0;
    done  = '0;
    launch(4'b1000);
    exp_v = {4'b1000, 1'b0, 1'b0, 1'b1, 4'b1000};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL abort_restart_go: got %b want %b", obs(), exp_v);
    end
    done = 4'b1000;
    step();
    done = '0;
    exp_v = {4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL abort_restart_fin: got %b want %b", obs(), exp_v);
    end
    step();
  endtask

  // Asynchronous reset mid-round, then dones that must not produce fin.
  task automatic test_reset_mid_round();
    launch(4'b0011);
    done = 4'b0001;
    step();
    done = '0;
    exp_v = {4'b0000, 1'b0, 1'b0, 1'b1, 4'b0010};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL pre_reset: got %b want %b", obs(), exp_v);
    end
    rstn = 1'b0;
    #2;
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL async_reset: got %b want %b", obs(), 11'b0);
    end
    step();
    step();
    rstn = 1'b1;
    for (int r = 0; r < 4; r++) begin
      done = 4'b0011;
      step();
      total++;
      if (obs() !== 11'b0) begin
        bad++;
        $display("FAIL post_reset r=%0d: got %b want %b", r, obs(), 11'b0);
      end
    end
    done = '0;
  endtask

  // A second start while busy must not relaunch or change the round.
  task automatic test_start_while_busy();
    launch(4'b0001);
    exp_v = {4'b0001, 1'b0, 1'b0, 1'b1, 4'b0001};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL busy_first_go: got %b want %b", obs(), exp_v);
    end
    launch(4'b1111);
    exp_v = {4'b0000, 1'b0, 1'b0, 1'b1, 4'b0001};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL busy_ignore_start: got %b want %b", obs(), exp_v);
    end
    done = 4'b0001;
    step();
    done = '0;
    exp_v = {4'b0000, 1'b1, 1'b0, 1'b0, 4'b0000};
    total++;
    if (obs() !== exp_v) begin
      bad++;
      $display("FAIL busy_fin: got %b want %b", obs(), exp_v);
    end
    step();
    total++;
    if (obs() !== 11'b0) begin
      bad++;
      $display("FAIL busy_idle_after: got %b want %b", obs(), 11'b0);
    end
  endtask

  initial begin
    test_reset();
    test_full_join();
    test_timeout();
    test_degenerate_b2b();
    test_last_done_at_timeout();
    test_abort();
    test_reset_mid_round();
    test_start_while_busy();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule : tb_req_join_sched

// File: doc/req_join_sched.md
Name: req_join_sched

Overview:
- Clocked fork/join scheduler for flow-control completion detection.
- On a start pulse it fires one-cycle go pulses to a masked set of worker modules, then collects their done pulses in sticky bits.
- Emits a single fin pulse once every enabled worker has reported. Otherwise it emits a timeout pulse.
- Sits between a sequencing controller and up to REQ_NUM parallel operation modules. It replaces free-running edge-triggered join logic with a synchronous, resettable, abortable join.

Parameters:
- REQ_NUM, 4, number of worker channels (1..32).
- TIMEOUT_CYCLES, 1024, maximum WAIT cycles before timeout (>=2).
- CNT_W, $clog2(TIMEOUT_CYCLES), width of the timeout counter.

Ports:
- clk  in  1  system clock, rising edge.
- rstn  in  1  asynchronous active-low reset.
- start  in  1  one-cycle request to launch a round.
- mask  in  REQ_NUM  channels enabled for this round; sampled with start.
- abort  in  1  cancels the current round.
- go  out  REQ_NUM  one-cycle launch pulse per enabled channel.
- done  in  REQ_NUM  per-channel one-cycle completion pulse from workers.
- fin  out  1  one-cycle pulse: all enabled channels done.
- timeout  out  1  one-cycle pulse: round expired incomplete.
- busy  out  1  high while a round is in progress.
- pending  out  REQ_NUM  enabled channels not yet done (active & ~collected).

Behaviour:
- Reset (rstn=0, async):
  - State IDLE.
  - go, fin, timeout, busy, pending all 0.
  - Internal active, collected and counter cleared.
- States: IDLE, WAIT. All outputs are registered.
- IDLE, start=1 and mask!=0:
  - Latch active<=mask, clear collected and counter.
  - go<=mask for exactly one cycle, so go appears at T+1 for start at T.
  - busy<=1, next state WAIT.
- IDLE, start=1 and mask==0 (degenerate round): fin<=1 at T+1, go stays 0, remain IDLE, busy stays 0.
- WAIT, per cycle:
  - collected |= done & active.
  - done on inactive channels is ignored.
  - done on an already-collected channel has no effect.
- WAIT, completion: when (collected | (done & active)) == active, fin<=1 next cycle, busy<=0, return IDLE. Done sampled at D gives fin at D+1.
- WAIT, counter:
  - Increments every WAIT cycle.
  - If it reaches TIMEOUT_CYCLES-1 without completion: timeout<=1 for one cycle, busy<=0, IDLE.
  - pending holds its final value until the next accepted start, for diagnosis.
- Simultaneous completion and timeout in the same cycle: completion wins; fin only.
- abort=1 in WAIT:
  - Return to IDLE next cycle with busy=0, no fin and no timeout; pending cleared.
  - abort has priority over completion and timeout. abort in IDLE is ignored.
- start while busy: ignored, no queuing.
- start in the cycle fin or timeout is asserted: the FSM is already IDLE, so the start is accepted (back-to-back rounds, no dead cycle).
- Workers may assert done as early as the cycle go is high. done in the cycle go is asserted counts toward the round.
- done pulses arriving in IDLE are ignored.
- Reset mid-round: immediate return to the reset state; no fin or timeout is generated.
- pending = active & ~collected in WAIT; 0 in IDLE, except after a timeout as stated above.

Decomposition:
- Shared flow-control package/header:
  - State encodings (ST_IDLE=1'b0, ST_WAIT=1'b1).
  - Default REQ_NUM and TIMEOUT_CYCLES constants.
  - Clog2 helper if not already present.
- One natural sub-module, done_collector: REQ_NUM sticky-bit vector with synchronous clear, enable mask, and an all_done output (combinational on collected|done&active).
- FSM, counter and output registers stay in req_join_sched.

Test Plan:
- Reset, then start with mask=4'b1111 at T -> go=4'b1111 only at T+1. Done pulses on ch0..3 at T+3, T+5, T+5, T+9 -> fin=1 only at T+10, busy falls at T+10, pending sequence 1111→1110→1000→0000.
- mask=4'b0101; done on ch1 and ch3 only, repeated -> no fin, timeout pulses exactly TIMEOUT_CYCLES after go, pending=4'b0101 held afterwards.
- mask=0 start -> fin at T+1, go never asserts. Then start mask=4'b0010 in the fin cycle -> accepted, go=4'b0010 next cycle.
- Last done lands on the same cycle the counter hits TIMEOUT_CYCLES-1 -> fin=1, timeout=0.
- abort mid-WAIT with two channels still pending -> busy=0 next cycle, no fin or timeout. Later done pulses are ignored, and a new start behaves normally.
- Drive rstn low mid-WAIT, release, then send done pulses -> no fin. Also: start while busy is ignored (no second go).
